// File: rtl/cpu_cache_pkg.sv
// Shared types and helpers for the CPU bus cache.
package cpu_cache_pkg;

    localparam int unsigned ADDR_W = 32;
    localparam int unsigned DATA_W = 32;

    // Controller states
    typedef enum logic [2:0] {
        ST_FLUSH       = 3'd0,
        ST_IDLE        = 3'd1,
        ST_READ_MISS   = 3'd2,
        ST_MEM_WRITE   = 3'd3,
        ST_MEM_READ_UC = 3'd4,
        ST_ACK         = 3'd5
    } cache_state_e;

    // Memory-side request payload
    typedef struct packed {
        logic              rw;
        logic [ADDR_W-1:0] addr;
        logic [DATA_W-1:0] wdata;
    } mem_req_t;

    // Tag width for a word-addressed, direct-mapped cache
    function automatic int unsigned tag_w(input int unsigned index_bits);
        return 30 - index_bits;
    endfunction

endpackage

// File: rtl/cpu_cache_line_ram.sv
// Line storage: {valid, tag, data} per index, async read, sync write, separate valid clear.
module cpu_cache_line_ram
    import cpu_cache_pkg::*;
#(
    parameter int unsigned INDEX_BITS = 8,
    parameter int unsigned TAG_W      = 22
) (
    input  logic                  i_clock,
    input  logic [INDEX_BITS-1:0] i_rd_index,
    output logic                  o_rd_valid,
    output logic [TAG_W-1:0]      o_rd_tag,
    output logic [DATA_W-1:0]     o_rd_data,
    input  logic                  i_wr_en,
    input  logic [INDEX_BITS-1:0] i_wr_index,
    input  logic [TAG_W-1:0]      i_wr_tag,
    input  logic [DATA_W-1:0]     i_wr_data,
    input  logic                  i_clr_en,
    input  logic [INDEX_BITS-1:0] i_clr_index
);

    localparam int unsigned LINES = 1 << INDEX_BITS;

    logic              valid_mem [LINES];
    logic [TAG_W-1:0]  tag_mem   [LINES];
    logic [DATA_W-1:0] data_mem  [LINES];

    // Valid bits: the flush sweep clears, a write or fill sets
    always_ff @(posedge i_clock) begin
        if (i_clr_en) begin
            valid_mem[i_clr_index] <= 1'b0;
        end
        if (i_wr_en) begin
            valid_mem[i_wr_index] <= 1'b1;
        end
    end

    // Tag and data payload
    always_ff @(posedge i_clock) begin
        if (i_wr_en) begin
            tag_mem[i_wr_index]  <= i_wr_tag;
            data_mem[i_wr_index] <= i_wr_data;
        end
    end

    // Combinational lookup
    always_comb begin
        o_rd_valid = valid_mem[i_rd_index];
        o_rd_tag   = tag_mem[i_rd_index];
        o_rd_data  = data_mem[i_rd_index];
    end

endmodule

// File: rtl/cpu_bus_cache.sv
// Direct-mapped, write-through, one-word-line cache between the CPU bus and memory.
module cpu_bus_cache
    import cpu_cache_pkg::*;
#(
    parameter int unsigned       INDEX_BITS    = 8,
    parameter logic [ADDR_W-1:0] UNCACHED_BASE = 32'h5000_0000
) (
    input  logic              i_clock,
    input  logic              i_reset,
    input  logic              i_flush,
    output logic              o_flush_busy,
    input  logic              i_cpu_rw,
    input  logic              i_cpu_request,
    output logic              o_cpu_ready,
    input  logic [ADDR_W-1:0] i_cpu_address,
    input  logic [DATA_W-1:0] i_cpu_wdata,
    output logic [DATA_W-1:0] o_cpu_rdata,
    output logic              o_mem_rw,
    output logic              o_mem_request,
    input  logic              i_mem_ready,
    output logic [ADDR_W-1:0] o_mem_address,
    input  logic [DATA_W-1:0] i_mem_rdata,
    output logic [DATA_W-1:0] o_mem_wdata,
    output logic [31:0]       o_hit_count,
    output logic [31:0]       o_miss_count
);

    localparam int unsigned           TAG_W    = tag_w(INDEX_BITS);
    localparam logic [INDEX_BITS-1:0] LAST_IDX = '1;

    cache_state_e          state_q, state_d;
    logic                  flush_pending_q, flush_pending_d;
    logic [INDEX_BITS-1:0] flush_idx_q, flush_idx_d;
    logic                  flush_busy_d;
    logic                  cpu_ready_d;
    logic [DATA_W-1:0]     cpu_rdata_d;
    logic                  mem_request_d;
    mem_req_t              mem_req_q, mem_req_d;
    logic [31:0]           hit_count_d, miss_count_d;

    logic [INDEX_BITS-1:0] cpu_idx;
    logic [TAG_W-1:0]      cpu_tag;
    logic                  uncached;
    logic                  hit;
    logic                  rd_valid;
    logic [TAG_W-1:0]      rd_tag;
    logic [DATA_W-1:0]     rd_data;

    logic                  wr_en;
    logic [INDEX_BITS-1:0] wr_index;
    logic [TAG_W-1:0]      wr_tag;
    logic [DATA_W-1:0]     wr_data;
    logic                  clr_en;

    // CPU address decode and hit detection
    always_comb begin
        cpu_idx  = i_cpu_address[INDEX_BITS+1:2];
        cpu_tag  = i_cpu_address[ADDR_W-1:INDEX_BITS+2];
        uncached = (i_cpu_address >= UNCACHED_BASE);
        hit      = rd_valid && (rd_tag == cpu_tag) && !uncached;
    end

    cpu_cache_line_ram #(
        .INDEX_BITS (INDEX_BITS),
        .TAG_W      (TAG_W)
    ) u_line_ram (
        .i_clock     (i_clock),
        .i_rd_index  (cpu_idx),
        .o_rd_valid  (rd_valid),
        .o_rd_tag    (rd_tag),
        .o_rd_data   (rd_data),
        .i_wr_en     (wr_en),
        .i_wr_index  (wr_index),
        .i_wr_tag    (wr_tag),
        .i_wr_data   (wr_data),
        .i_clr_en    (clr_en),
        .i_clr_index (flush_idx_q)
    );

    // State register
    always_ff @(posedge i_clock or negedge i_reset) begin
        if (!i_reset) begin
            state_q <= ST_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state, datapath and line-write control
    always_comb begin
        state_d         = state_q;
        flush_pending_d = flush_pending_q | i_flush;
        flush_idx_d     = flush_idx_q;
        cpu_ready_d     = 1'b0;
        cpu_rdata_d     = o_cpu_rdata;
        mem_request_d   = o_mem_request;
        mem_req_d       = mem_req_q;
        hit_count_d     = o_hit_count;
        miss_count_d    = o_miss_count;
        wr_en           = 1'b0;
        wr_index        = cpu_idx;
        wr_tag          = cpu_tag;
        wr_data         = i_cpu_wdata;
        clr_en          = 1'b0;

        case (state_q)
            ST_IDLE: begin
                if (flush_pending_q) begin
                    // The entry cycle already clears line 0 so a sweep is exactly 2**INDEX_BITS cycles
                    clr_en          = 1'b1;
                    flush_idx_d     = flush_idx_q + INDEX_BITS'(1);
                    flush_pending_d = i_flush;
                    state_d         = ST_FLUSH;
                end else if (i_cpu_request) begin
                    mem_req_d.rw    = i_cpu_rw;
                    mem_req_d.addr  = {i_cpu_address[ADDR_W-1:2], 2'b00};
                    mem_req_d.wdata = i_cpu_wdata;
                    if (i_cpu_rw) begin
                        wr_en         = hit;
                        mem_request_d = 1'b1;
                        state_d       = ST_MEM_WRITE;
                    end else if (uncached) begin
                        mem_request_d = 1'b1;
                        state_d       = ST_MEM_READ_UC;
                    end else if (hit) begin
                        cpu_rdata_d = rd_data;
                        hit_count_d = o_hit_count + 32'd1;
                        cpu_ready_d = 1'b1;
                        state_d     = ST_ACK;
                    end else begin
                        miss_count_d  = o_miss_count + 32'd1;
                        mem_request_d = 1'b1;
                        state_d       = ST_READ_MISS;
                    end
                end
            end
            ST_FLUSH: begin
                clr_en      = 1'b1;
                flush_idx_d = flush_idx_q + INDEX_BITS'(1);
                if (flush_idx_q == LAST_IDX) begin
                    state_d = ST_IDLE;
                end
            end
            ST_READ_MISS: begin
                if (i_mem_ready) begin
                    wr_en         = 1'b1;
                    wr_index      = mem_req_q.addr[INDEX_BITS+1:2];
                    wr_tag        = mem_req_q.addr[ADDR_W-1:INDEX_BITS+2];
                    wr_data       = i_mem_rdata;
                    cpu_rdata_d   = i_mem_rdata;
                    mem_request_d = 1'b0;
                    cpu_ready_d   = 1'b1;
                    state_d       = ST_ACK;
                end
            end
            ST_MEM_READ_UC: begin
                if (i_mem_ready) begin
                    cpu_rdata_d   = i_mem_rdata;
                    mem_request_d = 1'b0;
                    cpu_ready_d   = 1'b1;
                    state_d       = ST_ACK;
                end
            end
            ST_MEM_WRITE: begin
                if (i_mem_ready) begin
                    mem_request_d = 1'b0;
                    cpu_ready_d   = 1'b1;
                    state_d       = ST_ACK;
                end
            end
            ST_ACK: begin
                state_d = ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase

        // Busy covers the sweep plus the IDLE cycle that launches it
        flush_busy_d = (state_d == ST_FLUSH) || ((state_d == ST_IDLE) && flush_pending_d);
    end

    // Registered outputs, flush control and counters
    always_ff @(posedge i_clock or negedge i_reset) begin
        if (!i_reset) begin
            flush_pending_q <= 1'b1;
            flush_idx_q     <= '0;
            o_flush_busy    <= 1'b1;
            o_cpu_ready     <= 1'b0;
            o_cpu_rdata     <= '0;
            o_mem_request   <= 1'b0;
            mem_req_q       <= '0;
            o_hit_count     <= '0;
            o_miss_count    <= '0;
        end else begin
            flush_pending_q <= flush_pending_d;
            flush_idx_q     <= flush_idx_d;
            o_flush_busy    <= flush_busy_d;
            o_cpu_ready     <= cpu_ready_d;
            o_cpu_rdata     <= cpu_rdata_d;
            o_mem_request   <= mem_request_d;
            mem_req_q       <= mem_req_d;
            o_hit_count     <= hit_count_d;
            o_miss_count    <= miss_count_d;
        end
    end

    // Memory bus fields come straight from the request register
    always_comb begin
        o_mem_rw      = mem_req_q.rw;
        o_mem_address = mem_req_q.addr;
        o_mem_wdata   = mem_req_q.wdata;
    end

endmodule
